// File: rtl/match_dictionary.sv
// Move-to-front dictionary of recent words: compares an accepted word against every
// entry, holds registered per-entry match results, then applies the downstream decision.
module match_dictionary #(
   parameter int NO_WORD          = 16,
   parameter int WORD_WIDTH       = 32,
   parameter int WIDTH_MATCH_BYTE = 2,
   localparam int IDX_W           = $clog2(NO_WORD)
) (
   input  logic                                i_clk,
   input  logic                                i_reset,
   input  logic                                i_valid,
   output logic                                o_ready,
   input  logic [WORD_WIDTH-1:0]               i_data,
   input  logic                                i_flush,
   output logic                                o_valid,
   output logic [WORD_WIDTH-1:0]               o_word,
   output logic [WIDTH_MATCH_BYTE*NO_WORD-1:0] o_no_byte_matched,
   output logic [NO_WORD-1:0]                  o_align,
   output logic [4*NO_WORD-1:0]                o_match_mask,
   input  logic                                i_upd_valid,
   input  logic                                i_upd_hit,
   input  logic [IDX_W-1:0]                    i_upd_idx
);

   typedef enum logic {IDLE, CMP} state_t;

   state_t state_p0, state_nxt;

   logic [WORD_WIDTH-1:0] dict_word_p0 [NO_WORD];
   logic                  dict_vld_p0  [NO_WORD];

   logic [4*NO_WORD-1:0]                cmp_mask;
   logic [WIDTH_MATCH_BYTE*NO_WORD-1:0] cmp_code;
   logic [NO_WORD-1:0]                  cmp_align;
   logic [NO_WORD-1:0]                  shift_en;
   logic                                accept;
   logic                                commit;
   logic                                hit_ok;

   function automatic logic [WIDTH_MATCH_BYTE-1:0] match_code(input logic [3:0] m);
      case ($countones(m))
         4:       return WIDTH_MATCH_BYTE'(3);
         3:       return WIDTH_MATCH_BYTE'(2);
         2:       return WIDTH_MATCH_BYTE'(1);
         default: return '0;
      endcase
   endfunction

   // Only runs of two or more adjacent equal bytes are useful to the encoder.
   function automatic logic match_align(input logic [3:0] m);
      case (m)
         4'b1111, 4'b1110, 4'b0111,
         4'b1100, 4'b0110, 4'b0011: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   assign o_ready = (state_p0 == IDLE);
   assign o_valid = (state_p0 == CMP);
   assign accept  = (state_p0 == IDLE) && i_valid && !i_flush;
   assign commit  = (state_p0 == CMP) && i_upd_valid && !i_flush;
   assign hit_ok  = i_upd_hit && dict_vld_p0[i_upd_idx];

   always_comb begin
      cmp_mask  = '0;
      cmp_code  = '0;
      cmp_align = '0;
      for (int i = 0; i < NO_WORD; i++) begin
         for (int k = 0; k < 4; k++)
            cmp_mask[4*i+k] = dict_vld_p0[i] &&
                              (dict_word_p0[i][8*k +: 8] == i_data[8*k +: 8]);
         cmp_code[i*WIDTH_MATCH_BYTE +: WIDTH_MATCH_BYTE] = match_code(cmp_mask[4*i +: 4]);
         cmp_align[i] = match_align(cmp_mask[4*i +: 4]);
      end
   end

   // A hit on a valid entry shifts only the entries in front of it; anything else
   // behaves as a miss and shifts the whole dictionary.
   always_comb begin
      shift_en = '0;
      for (int i = 1; i < NO_WORD; i++)
         shift_en[i] = hit_ok ? (i <= int'(i_upd_idx)) : 1'b1;
   end

   always_comb begin
      state_nxt = state_p0;
      if (i_flush) begin
         state_nxt = IDLE;
      end else begin
         case (state_p0)
            IDLE:    if (i_valid) state_nxt = CMP;
            CMP:     if (i_upd_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_p0 <= IDLE;
      else         state_p0 <= state_nxt;
   end

   // stage p0: dictionary storage and move-to-front update
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NO_WORD; i++) begin
            dict_word_p0[i] <= '0;
            dict_vld_p0[i]  <= 1'b0;
         end
      end else if (i_flush) begin
         for (int i = 0; i < NO_WORD; i++) begin
            dict_word_p0[i] <= '0;
            dict_vld_p0[i]  <= 1'b0;
         end
      end else if (commit) begin
         for (int i = 1; i < NO_WORD; i++) begin
            if (shift_en[i]) begin
               dict_word_p0[i] <= dict_word_p0[i-1];
               dict_vld_p0[i]  <= dict_vld_p0[i-1];
            end
         end
         dict_word_p0[0] <= o_word;
         dict_vld_p0[0]  <= 1'b1;
      end
   end

   // stage p1: registered compare results, held for the whole CMP state
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_word            <= '0;
         o_no_byte_matched <= '0;
         o_align           <= '0;
         o_match_mask      <= '0;
      end else if (accept) begin
         o_word            <= i_data;
         o_no_byte_matched <= cmp_code;
         o_align           <= cmp_align;
         o_match_mask      <= cmp_mask;
      end
   end

endmodule

// File: tb/tb_match_dictionary.sv
// Scoreboard bench for match_dictionary: a list-based move-to-front model predicts each
// compare result; a monitor checks results whenever the DUT presents o_valid.
module tb_match_dictionary;

   localparam int NO_WORD = 16;
   localparam int IDX_W   = 4;

   logic                 i_clk = 1'b0;
   logic                 i_reset = 1'b1;
   logic                 i_valid = 1'b0;
   logic                 o_ready;
   logic [31:0]          i_data = '0;
   logic                 i_flush = 1'b0;
   logic                 o_valid;
   logic [31:0]          o_word;
   logic [2*NO_WORD-1:0] o_no_byte_matched;
   logic [NO_WORD-1:0]   o_align;
   logic [4*NO_WORD-1:0] o_match_mask;
   logic                 i_upd_valid = 1'b0;
   logic                 i_upd_hit = 1'b0;
   logic [IDX_W-1:0]     i_upd_idx = '0;

   match_dictionary #(.NO_WORD(NO_WORD), .WORD_WIDTH(32), .WIDTH_MATCH_BYTE(2)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_flush(i_flush), .o_valid(o_valid), .o_word(o_word),
      .o_no_byte_matched(o_no_byte_matched), .o_align(o_align),
      .o_match_mask(o_match_mask), .i_upd_valid(i_upd_valid),
      .i_upd_hit(i_upd_hit), .i_upd_idx(i_upd_idx)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] word;
      logic [31:0] code;
      logic [15:0] align;
      logic [63:0] mask;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] dict[$];      // front = most recent; only valid entries are kept
   logic [31:0] last_word;
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic exp_t model_cmp(input logic [31:0] w);
      exp_t        e;
      int          cnt;
      int          s;
      logic [3:0]  m;
      e.word = w; e.code = '0; e.align = '0; e.mask = '0;
      for (int i = 0; i < dict.size(); i++) begin
         cnt = 0; m = '0;
         for (int k = 0; k < 4; k++)
            if (dict[i][8*k +: 8] == w[8*k +: 8]) begin m[k] = 1'b1; cnt++; end
         e.mask[4*i +: 4] = m;
         e.code[2*i +: 2] = (cnt == 4) ? 2'd3 : (cnt == 3) ? 2'd2 : (cnt == 2) ? 2'd1 : 2'd0;
         if (cnt >= 2) begin
            s = int'(m);
            while ((s & 1) == 0) s = s >> 1;
            e.align[i] = ((s & (s + 1)) == 0);
         end
      end
      return e;
   endfunction

   function automatic void model_update(input logic hit, input int idx, input logic [31:0] w);
      if (hit && idx < dict.size()) begin
         dict.delete(idx);
         dict.push_front(w);
      end else begin
         dict.push_front(w);
         if (dict.size() > NO_WORD) void'(dict.pop_back());
      end
   endfunction

   // Monitor: a new o_valid pulse takes the next expectation; held results are rechecked each cycle.
   initial begin
      exp_t cur;
      logic prev_v;
      logic have;
      prev_v = 1'b0; have = 1'b0;
      forever begin
         @(negedge i_clk);
         if (o_valid) begin
            if (!prev_v) begin
               if (exp_q.size() == 0) begin
                  have = 1'b0;
                  chk("unexpected_o_valid", 64'(o_valid), 64'(0));
               end else begin
                  cur  = exp_q.pop_front();
                  have = 1'b1;
               end
            end
            if (have) begin
               chk("o_word", 64'(o_word), 64'(cur.word));
               chk("o_no_byte_matched", 64'(o_no_byte_matched), 64'(cur.code));
               chk("o_align", 64'(o_align), 64'(cur.align));
               chk("o_match_mask", o_match_mask, cur.mask);
            end
         end
         prev_v = o_valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   task automatic do_accept(input logic [31:0] w);
      chk("ready_before_accept", 64'(o_ready), 64'(1));
      exp_q.push_back(model_cmp(w));
      last_word = w;
      i_valid = 1'b1; i_data = w;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      chk("valid_after_accept", 64'(o_valid), 64'(1));
      chk("ready_in_cmp", 64'(o_ready), 64'(0));
   endtask

   task automatic do_update(input logic hit, input int idx);
      i_upd_valid = 1'b1; i_upd_hit = hit; i_upd_idx = IDX_W'(idx);
      @(posedge i_clk); #1;
      i_upd_valid = 1'b0;
      model_update(hit, idx, last_word);
      chk("valid_after_update", 64'(o_valid), 64'(0));
      chk("ready_after_update", 64'(o_ready), 64'(1));
   endtask

   task automatic do_flush();
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      dict.delete();
      chk("valid_after_flush", 64'(o_valid), 64'(0));
      chk("ready_after_flush", 64'(o_ready), 64'(1));
   endtask

   task automatic check_entry(input string nm, input int i, input logic [3:0] m,
                              input logic [1:0] c, input logic a);
      chk({nm, "_mask"}, 64'(o_match_mask[4*i +: 4]), 64'(m));
      chk({nm, "_code"}, 64'(o_no_byte_matched[2*i +: 2]), 64'(c));
      chk({nm, "_align"}, 64'(o_align[i]), 64'(a));
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_ready"}, 64'(o_ready), 64'(1));
      chk({nm, "_valid"}, 64'(o_valid), 64'(0));
      chk({nm, "_word"}, 64'(o_word), 64'(0));
      chk({nm, "_code"}, 64'(o_no_byte_matched), 64'(0));
      chk({nm, "_align"}, 64'(o_align), 64'(0));
      chk({nm, "_mask"}, o_match_mask, 64'(0));
   endtask

   initial begin
      logic [31:0] w;
      int          sel;
      repeat (3) @(posedge i_clk);
      #1 i_reset = 1'b0;
      @(posedge i_clk); #1;
      check_reset_outputs("reset");

      // stray decision strobe while idle
      i_upd_valid = 1'b1; i_upd_hit = 1'b0;
      @(posedge i_clk); #1;
      i_upd_valid = 1'b0;
      chk("stray_upd_valid", 64'(o_valid), 64'(0));
      chk("stray_upd_ready", 64'(o_ready), 64'(1));

      do_accept(32'hAABBCCDD);
      chk("empty_codes", 64'(o_no_byte_matched), 64'(0));
      chk("empty_masks", o_match_mask, 64'(0));
      do_update(1'b0, 0);
      do_accept(32'hAABBCCDD);
      check_entry("repeat_e0", 0, 4'hF, 2'd3, 1'b1);
      do_update(1'b1, 0);

      do_accept(32'h11223344); do_update(1'b0, 0);
      do_accept(32'h11AA3344);
      check_entry("part_1011", 0, 4'b1011, 2'd2, 1'b0);
      do_update(1'b0, 0);
      do_accept(32'h11223344); do_update(1'b1, 1);
      do_accept(32'h1122AABB);
      check_entry("part_1100", 0, 4'b1100, 2'd1, 1'b1);
      do_update(1'b0, 0);
      do_accept(32'h11223344); do_update(1'b1, 1);
      do_accept(32'h11BBCCDD);
      check_entry("part_1000", 0, 4'b1000, 2'd0, 1'b0);
      do_update(1'b0, 0);

      // move-to-front: 17 misses then a hit at index 5
      do_flush();
      for (int k = 0; k < 17; k++) begin
         do_accept(32'h01010101 * (k + 1));
         do_update(1'b0, 0);
      end
      do_accept(32'hF0E0D0C0);
      do_update(1'b1, 5);
      do_accept(32'h0B0B0B0B);            // W10, expected at entry 6
      check_entry("mtf_w10", 6, 4'hF, 2'd3, 1'b1);
      do_update(1'b0, 0);
      do_accept(32'h01010101);            // W0 was dropped
      chk("mtf_w0_dropped", 64'(o_no_byte_matched), 64'(0));
      do_update(1'b0, 0);

      // flush during CMP, then a compare against the emptied dictionary
      do_accept(32'h0C0C0C0C);
      do_flush();
      do_accept(32'h0C0C0C0C);
      chk("post_flush_codes", 64'(o_no_byte_matched), 64'(0));
      do_update(1'b0, 0);

      // asynchronous reset mid-CMP
      do_accept(32'h0C0C0C0C);
      chk("pre_reset_code", 64'(o_no_byte_matched[1:0]), 64'(3));
      @(negedge i_clk); #1;
      i_reset = 1'b1;
      #1;
      check_reset_outputs("async_reset");
      dict.delete();
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      do_accept(32'h0C0C0C0C);
      chk("post_reset_codes", 64'(o_no_byte_matched), 64'(0));
      do_update(1'b0, 0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         repeat ($urandom_range(0, 2)) @(posedge i_clk);
         #1;
         if ($urandom_range(0, 29) == 0) begin
            i_valid = 1'b1; i_data = $urandom; i_flush = 1'b1;
            @(posedge i_clk); #1;
            i_valid = 1'b0; i_flush = 1'b0;
            dict.delete();
            chk("flush_idle_no_accept", 64'(o_valid), 64'(0));
            continue;
         end
         w = $urandom;
         if (dict.size() > 0 && $urandom_range(0, 3) != 0) begin
            sel = $urandom_range(0, dict.size() - 1);
            w = dict[sel];
            for (int k = 0; k < 4; k++)
               if ($urandom_range(0, 2) == 0) w[8*k +: 8] = 8'($urandom);
         end
         do_accept(w);
         repeat ($urandom_range(0, 2)) @(posedge i_clk);
         #1;
         if ($urandom_range(0, 24) == 0) do_flush();
         else do_update($urandom_range(0, 1) == 1, $urandom_range(0, NO_WORD - 1));
      end

      repeat (3) @(posedge i_clk);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/match_dictionary.md
# match_dictionary

Move-to-front match dictionary for the Stage 1 compression datapath, sitting directly upstream of the combinational max selector. The block holds NO_WORD previously seen 32-bit words and compares each accepted input word against every entry. It presents, per entry, a registered matched-byte count, an alignment flag and a byte mask, which the selector reduces to the best match. The dictionary then waits for the selector/encoder decision and performs the move-to-front update before accepting the next word.

## Interface
- NO_WORD, 16, dictionary depth (entry 0 = most recent)
- WORD_WIDTH, 32, data word width; fixed at 4 bytes
- WIDTH_MATCH_BYTE, 2, width of the per-entry match-count code
- i_clk  in  1  clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_valid  in  1  input word valid
- o_ready  out  1  block can accept a word
- i_data  in  WORD_WIDTH  word to compare and insert
- i_flush  in  1  invalidate whole dictionary
- o_valid  out  1  compare results valid and held
- o_word  out  WORD_WIDTH  registered copy of the word under compare
- o_no_byte_matched  out  WIDTH_MATCH_BYTE*NO_WORD  per-entry match code, entry i at [(i+1)*W-1:i*W]
- o_align  out  NO_WORD  per-entry contiguous-match flag
- o_match_mask  out  4*NO_WORD  per-entry byte-equal mask, entry i at [4i+3:4i]
- i_upd_valid  in  1  downstream decision strobe
- i_upd_hit  in  1  1 = match at i_upd_idx, 0 = miss
- i_upd_idx  in  $clog2(NO_WORD)  winning entry index

## Operation
- Storage: entry[i] (WORD_WIDTH), vld[i]. Reset/flush: all entries 0, all vld 0.
- Byte k = bits [8k+7:8k]; mask bit k = vld[i] && (entry[i] byte k == i_data byte k).
- Match code from popcount of mask: 4→3, 3→2, 2→1, 0/1→0. When code is 0, mask is still reported raw.
- o_align[i] = code≠0 and the set mask bits are adjacent (1111, 1110, 0111, 1100, 0110, 0011); else 0.
- FSM with two states:
  - IDLE: o_ready=1, o_valid=0. On i_valid, compare against the current dictionary and register all results plus o_word; go to CMP.
  - CMP: o_ready=0, o_valid=1, outputs held stable. On i_upd_valid, update the dictionary and go to IDLE.
- Update on hit, with h=i_upd_idx and vld[h]=1:
  - entry[1..h] ← entry[0..h-1] (with vld).
  - entry[0] ← o_word, vld[0] ← 1.
  - Entries above h are unchanged.
- Update on miss, or on a hit naming an invalid entry:
  - entry[1..NO_WORD-1] ← entry[0..NO_WORD-2]; the last entry is dropped.
  - entry[0] ← o_word, vld[0] ← 1.
- Hit at h=0: entry[0] is rewritten with o_word and the order is unchanged.
- i_upd_valid in IDLE is ignored. i_valid in CMP is not accepted (o_ready=0).
- i_flush has priority over everything:
  - Clears all vld and entries.
  - In CMP, aborts to IDLE with no insert.
  - In IDLE with i_valid high, the word is not accepted.

## Timing
- Reset values: o_ready=1, o_valid=0, o_word=0, o_no_byte_matched=0, o_align=0, o_match_mask=0, state IDLE.
- Accept in cycle t → o_valid=1 and results stable from t+1.
- i_upd_valid in cycle u (≥t+1):
  - The dictionary is updated at the edge ending u.
  - o_valid=0 and o_ready=1 in u+1.
  - The next accept is possible in u+1. Peak throughput is 1 word per 2 cycles.
- The downstream selector is combinational on the registered outputs, so i_upd_valid may assert in t+1.
- o_ready is decoded from the registered state only, with no combinational path from i_valid.
- i_flush in cycle f: the edge ending f clears state; o_valid=0 and o_ready=1 in f+1.
- Asynchronous reset mid-CMP: all outputs go immediately to their reset values and the dictionary is emptied.

## Test plan
- Reset, then idle:
  - o_ready=1, o_valid=0, all result buses 0.
  - A stray i_upd_valid changes nothing.
- Empty-dictionary compare:
  - Input 0xAABBCCDD: o_valid in the next cycle with all codes 0, masks 0, o_word=0xAABBCCDD.
  - Miss update: entry0=0xAABBCCDD, vld0=1.
- Repeat 0xAABBCCDD:
  - Entry 0 reports code 3, mask 0xF, align 1; all other entries code 0.
  - Hit idx 0 leaves the order unchanged.
- Partial matches with entry0=0x11223344:
  - Input 0x11AA3344 → mask 1011, code 2, align 0.
  - Input 0x1122AABB → mask 1100, code 1, align 1.
  - Input 0x11BBCCDD → mask 1000, code 0, align 0.
- Move-to-front:
  - Insert 17 distinct words W0..W16 by misses: W16 at entry0, W1 at entry15, W0 dropped.
  - Hit at idx 5 with new word X: entry0=X, entries 1..5 = old entries 0..4, entries 6..15 unchanged.
- Flush during CMP:
  - Assert i_flush while o_valid=1 → next cycle o_valid=0, o_ready=1, no insert.
  - The following compare reports all codes 0.
  - Repeat the same sequence with i_reset instead, asserted mid-CMP.
